// File: rtl/obstacle_scheduler.sv
// Obstacle table controller for the VGA renderer: spawns, scrolls and retires
// up to ten obstacles once per frame tick, with a free-running LFSR for geometry.
module obstacle_scheduler #(
    parameter int unsigned SCREEN_W       = 640,
    parameter int unsigned OBST_W         = 40,
    parameter int unsigned MIN_H          = 60,
    parameter int unsigned UPPER_BOUND    = 20,
    parameter int unsigned LOWER_BOUND    = 460,
    parameter int unsigned SPAWN_GAP      = 90,
    parameter int unsigned SPEED_INIT     = 2,
    parameter int unsigned SPEED_MAX      = 8,
    parameter int unsigned SPEEDUP_FRAMES = 600,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic [1:0]       gamemode,
    output logic [9:0][19:0] obstacle_x,
    output logic [9:0][17:0] obstacle_y,
    output logic [9:0]       active,
    output logic [3:0]       speed
);

    localparam int unsigned NSLOT = 10;
    localparam int unsigned XW    = 10;
    localparam int unsigned YW    = 9;
    localparam int unsigned SW    = 4;
    localparam int unsigned GAP_W = (SPAWN_GAP < 2) ? 1 : $clog2(SPAWN_GAP + 1);
    localparam int unsigned SUP_W = (SPEEDUP_FRAMES < 2) ? 1 : $clog2(SPEEDUP_FRAMES + 1);

    localparam logic [XW-1:0] SPAWN_L = XW'(SCREEN_W);
    localparam logic [XW-1:0] SPAWN_R = XW'(SCREEN_W + OBST_W);
    localparam logic [YW-1:0] TOP_Y   = YW'(UPPER_BOUND + 1);
    localparam logic [YW-1:0] BOT_Y   = YW'(LOWER_BOUND);

    typedef enum logic [1:0] {
        MODE_INIT  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_PAUSE = 2'b10,
        MODE_END   = 2'b11
    } mode_e;

    logic [NSLOT-1:0][2*XW-1:0] r_x, w_x_nxt;
    logic [NSLOT-1:0][2*YW-1:0] r_y, w_y_nxt;
    logic [NSLOT-1:0]           r_active, w_act_nxt;
    logic [SW-1:0]              r_speed, w_speed_nxt;
    logic [GAP_W-1:0]           r_spawn_cnt, w_gap_nxt;
    logic [SUP_W-1:0]           r_sup_cnt, w_sup_nxt;
    logic [15:0]                r_lfsr, w_lfsr_nxt;

    mode_e         w_mode;
    logic          w_free_found;
    logic [3:0]    w_free_idx;
    logic [YW-1:0] w_h;
    logic [XW-1:0] w_spd_x;

    assign w_mode     = mode_e'(gamemode);
    assign w_h        = YW'(MIN_H) + YW'(r_lfsr[6:0]);
    assign w_spd_x    = XW'(r_speed);
    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    // Lowest inactive slot, judged on the table as it stood before this tick
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = 4'd0;
        for (int i = int'(NSLOT) - 1; i >= 0; i--) begin
            if (!r_active[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = 4'(i);
            end
        end
    end

    // Next-state for table, speed and counters
    always_comb begin
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_act_nxt   = r_active;
        w_speed_nxt = r_speed;
        w_gap_nxt   = r_spawn_cnt;
        w_sup_nxt   = r_sup_cnt;
        case (w_mode)
            MODE_INIT: begin
                w_x_nxt     = '0;
                w_y_nxt     = '0;
                w_act_nxt   = '0;
                w_speed_nxt = SW'(SPEED_INIT);
                w_gap_nxt   = GAP_W'(SPAWN_GAP);
                w_sup_nxt   = '0;
            end
            MODE_RUN: begin
                if (frame_tick) begin
                    for (int i = 0; i < int'(NSLOT); i++) begin
                        if (r_active[i]) begin
                            if (r_x[i][XW-1:0] <= w_spd_x) begin
                                w_x_nxt[i]   = '0;
                                w_y_nxt[i]   = '0;
                                w_act_nxt[i] = 1'b0;
                            end else begin
                                w_x_nxt[i] = {(r_x[i][2*XW-1:XW] >= w_spd_x) ?
                                                  r_x[i][2*XW-1:XW] - w_spd_x : XW'(0),
                                              r_x[i][XW-1:0] - w_spd_x};
                            end
                        end
                    end
                    if (r_spawn_cnt != '0) begin
                        w_gap_nxt = r_spawn_cnt - GAP_W'(1);
                    end else if (w_free_found) begin
                        w_x_nxt[w_free_idx]   = {SPAWN_L, SPAWN_R};
                        w_y_nxt[w_free_idx]   = r_lfsr[15] ? {BOT_Y - w_h, BOT_Y}
                                                           : {TOP_Y, TOP_Y + w_h};
                        w_act_nxt[w_free_idx] = 1'b1;
                        w_gap_nxt             = GAP_W'(SPAWN_GAP);
                    end
                    if (r_sup_cnt == SUP_W'(SPEEDUP_FRAMES - 1)) begin
                        w_sup_nxt = '0;
                        if (r_speed < SW'(SPEED_MAX)) begin
                            w_speed_nxt = r_speed + SW'(1);
                        end
                    end else begin
                        w_sup_nxt = r_sup_cnt + SUP_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_active    <= '0;
            r_speed     <= SW'(SPEED_INIT);
            r_spawn_cnt <= GAP_W'(SPAWN_GAP);
            r_sup_cnt   <= '0;
            r_lfsr      <= LFSR_SEED;
        end else begin
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_active    <= w_act_nxt;
            r_speed     <= w_speed_nxt;
            r_spawn_cnt <= w_gap_nxt;
            r_sup_cnt   <= w_sup_nxt;
            r_lfsr      <= w_lfsr_nxt;
        end
    end

    assign obstacle_x = r_x;
    assign obstacle_y = r_y;
    assign active     = r_active;
    assign speed      = r_speed;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench for obstacle_scheduler: four parameterisations driven in lockstep
// against a behavioural model, plus directed checks of the key frame counts.
module tb_obstacle_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [1:0] gamemode = 2'b01;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0][19:0] x;
        logic [9:0][17:0] y;
        logic [9:0]       act;
        logic [3:0]       spd;
    } exp_t;

    logic [9:0][19:0] ox [4];
    logic [9:0][17:0] oy [4];
    logic [9:0]       oa [4];
    logic [3:0]       os [4];

    obstacle_scheduler u_dut_main (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .gamemode(gamemode),
        .obstacle_x(ox[0]), .obstacle_y(oy[0]), .active(oa[0]), .speed(os[0]));

    obstacle_scheduler #(.SPAWN_GAP(1), .SPEED_INIT(0)) u_dut_full (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .gamemode(gamemode),
        .obstacle_x(ox[1]), .obstacle_y(oy[1]), .active(oa[1]), .speed(os[1]));

    obstacle_scheduler #(.SPEEDUP_FRAMES(4)) u_dut_spd (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .gamemode(gamemode),
        .obstacle_x(ox[2]), .obstacle_y(oy[2]), .active(oa[2]), .speed(os[2]));

    obstacle_scheduler #(.SCREEN_W(8), .SPAWN_GAP(0), .SPEED_INIT(8)) u_dut_geo (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .gamemode(gamemode),
        .obstacle_x(ox[3]), .obstacle_y(oy[3]), .active(oa[3]), .speed(os[3]));

    int p_sw  [4] = '{640, 640, 640, 8};
    int p_gap [4] = '{90, 1, 90, 0};
    int p_sini[4] = '{2, 0, 2, 8};
    int p_sfr [4] = '{600, 600, 4, 600};

    int   m_l [4][10];
    int   m_r [4][10];
    int   m_t [4][10];
    int   m_b [4][10];
    bit   m_a [4][10];
    int   m_spd [4];
    int   m_gap [4];
    int   m_sup [4];
    int   spawn_slot [4];
    logic [15:0] lfsr;
    int   n_tick;
    int   geo_spawns;
    int   n_checks;
    int   n_fail;
    exp_t sb_q [$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset(input int k);
        for (int i = 0; i < 10; i++) begin
            m_l[k][i] = 0; m_r[k][i] = 0; m_t[k][i] = 0; m_b[k][i] = 0; m_a[k][i] = 1'b0;
        end
        m_spd[k] = p_sini[k];
        m_gap[k] = p_gap[k];
        m_sup[k] = 0;
    endtask

    task automatic model_step(input int k, input logic [1:0] mode, input logic tick);
        int fr;
        int h;
        spawn_slot[k] = -1;
        if (mode == 2'b00) begin
            model_reset(k);
        end else if (mode == 2'b01 && tick) begin
            fr = -1;
            for (int i = 9; i >= 0; i--) if (!m_a[k][i]) fr = i;
            for (int i = 0; i < 10; i++) begin
                if (m_a[k][i]) begin
                    if (m_r[k][i] <= m_spd[k]) begin
                        m_l[k][i] = 0; m_r[k][i] = 0; m_t[k][i] = 0; m_b[k][i] = 0;
                        m_a[k][i] = 1'b0;
                    end else begin
                        m_r[k][i] = m_r[k][i] - m_spd[k];
                        m_l[k][i] = (m_l[k][i] >= m_spd[k]) ? m_l[k][i] - m_spd[k] : 0;
                    end
                end
            end
            if (m_gap[k] > 0) begin
                m_gap[k]--;
            end else if (fr >= 0) begin
                h = 60 + int'(lfsr[6:0]);
                m_l[k][fr] = p_sw[k];
                m_r[k][fr] = p_sw[k] + 40;
                if (lfsr[15]) begin
                    m_t[k][fr] = 460 - h; m_b[k][fr] = 460;
                end else begin
                    m_t[k][fr] = 21; m_b[k][fr] = 21 + h;
                end
                m_a[k][fr]    = 1'b1;
                m_gap[k]      = p_gap[k];
                spawn_slot[k] = fr;
            end
            m_sup[k]++;
            if (m_sup[k] == p_sfr[k]) begin
                m_sup[k] = 0;
                if (m_spd[k] < 8) m_spd[k]++;
            end
        end
    endtask

    function automatic exp_t model_exp(input int k);
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            e.x[i]   = {10'(m_l[k][i]), 10'(m_r[k][i])};
            e.y[i]   = {9'(m_t[k][i]), 9'(m_b[k][i])};
            e.act[i] = m_a[k][i];
        end
        e.spd = 4'(m_spd[k]);
        return e;
    endfunction

    // One clock: drive at negedge, queue expectations, compare just after posedge
    task automatic cycle(input logic r, input logic [1:0] mode, input logic tick);
        exp_t e;
        int   s;
        int   top;
        int   bot;
        int   h;
        @(negedge clk);
        rst = r; gamemode = mode; frame_tick = tick;
        for (int k = 0; k < 4; k++) begin
            if (r) begin
                model_reset(k);
                spawn_slot[k] = -1;
            end else begin
                model_step(k, mode, tick);
            end
            sb_q.push_back(model_exp(k));
        end
        if (r) begin
            lfsr = 16'hACE1;
            n_tick = 0;
        end else begin
            if (mode == 2'b00) n_tick = 0;
            else if (mode == 2'b01 && tick) n_tick++;
            lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = sb_q.pop_front();
            check($sformatf("x%0d", k),   256'(ox[k]), 256'(e.x));
            check($sformatf("y%0d", k),   256'(oy[k]), 256'(e.y));
            check($sformatf("act%0d", k), 256'(oa[k]), 256'(e.act));
            check($sformatf("spd%0d", k), 256'(os[k]), 256'(e.spd));
            if (spawn_slot[k] >= 0) begin
                s   = spawn_slot[k];
                top = int'(oy[k][s][17:9]);
                bot = int'(oy[k][s][8:0]);
                h   = bot - top;
                check($sformatf("geom%0d", k),
                      256'((h >= 60 && h <= 187) && ((top == 21) || (bot == 460))), 256'(1));
                if (k == 3) geo_spawns++;
            end
        end
    endtask

    task automatic game_tick(input logic [1:0] mode);
        cycle(1'b0, mode, 1'b1);
        cycle(1'b0, mode, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog elapsed checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0; n_fail = 0; geo_spawns = 0; n_tick = 0;
        lfsr = 16'hACE1;
        for (int k = 0; k < 4; k++) begin
            model_reset(k);
            spawn_slot[k] = -1;
        end

        cycle(1'b1, 2'b01, 1'b0);
        cycle(1'b1, 2'b01, 1'b1);
        check("rst_act", 256'(oa[0]), 256'(0));
        check("rst_spd", 256'(os[0]), 256'(2));
        check("rst_x", 256'(ox[0]), 256'(0));

        while (n_tick < 40) begin
            game_tick(2'b01);
            if (n_tick == 3)  check("spd_t3", 256'(os[2]), 256'(2));
            if (n_tick == 4)  check("spd_t4", 256'(os[2]), 256'(3));
            if (n_tick == 8)  check("spd_t8", 256'(os[2]), 256'(4));
            if (n_tick == 24) check("spd_t24", 256'(os[2]), 256'(8));
            if (n_tick == 40) check("spd_t40", 256'(os[2]), 256'(8));
            if (n_tick == 19) check("full_t19", 256'(oa[1]), 256'(10'h1FF));
            if (n_tick == 20) check("full_t20", 256'(oa[1]), 256'(10'h3FF));
        end
        check("full_hold", 256'(oa[1]), 256'(10'h3FF));

        while (n_tick < 90) game_tick(2'b01);
        check("no_spawn90", 256'(oa[0]), 256'(0));
        game_tick(2'b01);
        check("spawn91_act", 256'(oa[0]), 256'(10'h001));
        check("spawn91_x", 256'(ox[0][0]), 256'({10'd640, 10'd680}));

        repeat (10) game_tick(2'b01);
        check("scroll10", 256'(ox[0][0]), 256'({10'd620, 10'd660}));

        repeat (50) game_tick(2'b10);
        check("pause_x", 256'(ox[0][0]), 256'({10'd620, 10'd660}));
        repeat (50) game_tick(2'b11);
        check("ended_x", 256'(ox[0][0]), 256'({10'd620, 10'd660}));

        repeat (329) game_tick(2'b01);
        check("pre_retire_x", 256'(ox[0][0]), 256'({10'd0, 10'd2}));
        check("pre_retire_a", 256'(oa[0][0]), 256'(1));
        game_tick(2'b01);
        check("retire_a", 256'(oa[0][0]), 256'(0));
        check("retire_x", 256'(ox[0][0]), 256'(0));

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_act", 256'(oa[0]), 256'(0));
        check("arst_x", 256'(ox[0]), 256'(0));
        check("arst_spd", 256'(os[2]), 256'(2));
        cycle(1'b1, 2'b01, 1'b0);

        repeat (10) game_tick(2'b01);
        check("pre_clr_spd", 256'(os[2]), 256'(4));
        cycle(1'b0, 2'b00, 1'b1);
        check("clr_act", 256'(oa[1]), 256'(0));
        check("clr_spd", 256'(os[2]), 256'(2));
        cycle(1'b0, 2'b00, 1'b0);

        repeat (30) cycle(1'b0, 2'b01, 1'b1);
        check("geo_count", 256'(geo_spawns >= 200), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
